// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE-array sequencer and the PE array itself:
// state encoding, control-vector bit positions and MAC pipeline depth.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WT,
    S_LOAD_IF,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  // pe_mux_ctrl fields
  localparam int MUX_ACTN_IN = 0;
  localparam int MUX_WT_IN   = 1;
  localparam int MUX_ADD_IN  = 2;
  localparam int MUX_PE_OUT  = 3;

  // pe_compute_ctrl fields
  localparam int CMP_MULT_EN   = 0;
  localparam int CMP_ADD_EN    = 1;
  localparam int CMP_ACC_CLR   = 2;
  localparam int CMP_MULT_LOAD = 3;
  localparam int CMP_ACC_WR_EN = 4;

  // Cycles from operand load to the first accumulator write
  localparam int MAC_PIPE_DEPTH = 2;

endpackage

// File: rtl/pe_row_sweep.sv
// Row pointer with one-hot decode; steps through rows 0..N-1 and wraps to 0.
module pe_row_sweep #(
  parameter int N = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         advance,
  output logic [W-1:0] row,
  output logic [N-1:0] onehot
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
    end else if (advance) begin
      row <= (row == W'(N - 1)) ? '0 : row + 1'b1;
    end
  end

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = (row == W'(i));
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for the PE array: weight load, then per pass activation
// load, fixed-length MAC window and row-by-row drain.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int Y_DIM  = 5,
  parameter int MAX_K  = 5,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        cfg_filt_size,
  input  logic [PASS_W-1:0] cfg_num_pass,
  input  logic              feed_valid,
  output logic              feed_ready,
  input  logic              drain_ready,
  output logic [3:0]        pe_mux_ctrl,
  output logic [4:0]        pe_compute_ctrl,
  output logic              pe_wt_rf_wr_en,
  output logic [Y_DIM-1:0]  pe_if_rf_wr_en,
  output logic [Y_DIM-1:0]  pe_of_rf_wr_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IF_W  = $clog2(Y_DIM * MAX_K);
  localparam int ROW_W = (Y_DIM > 1) ? $clog2(Y_DIM) : 1;

  state_t            state;
  logic [3:0]        k_q;
  logic [4:0]        kk_q;
  logic [IF_W-1:0]   if_last_q;
  logic [PASS_W-1:0] pass_last_q;
  logic [PASS_W-1:0] pass_cnt;
  logic [4:0]        wt_cnt;
  logic [IF_W-1:0]   if_cnt;
  logic [3:0]        row_beat;
  logic [5:0]        mac_cnt;
  logic [5:0]        mac_last;
  logic              cfg_err_q;
  logic              cfg_legal;

  logic              sweep_clear;
  logic              sweep_adv;
  logic [ROW_W-1:0]  row;
  logic [Y_DIM-1:0]  row_onehot;

  assign cfg_legal = (cfg_filt_size != 4'd0) && (cfg_filt_size <= 4'(MAX_K))
                     && (cfg_num_pass != '0);
  assign mac_last  = {1'b0, kk_q} + 6'(MAC_PIPE_DEPTH - 1);

  // One pointer serves both phases: it wraps to row 0 at the end of LOAD_IF,
  // so DRAIN always starts from the first row.
  assign sweep_clear = abort || (state == S_IDLE);
  assign sweep_adv   = ((state == S_LOAD_IF) && feed_valid && (row_beat == k_q - 4'd1))
                    || ((state == S_DRAIN) && drain_ready);

  pe_row_sweep #(
    .N (Y_DIM),
    .W (ROW_W)
  ) u_row_sweep (
    .clk     (clk),
    .rst     (rst),
    .clear   (sweep_clear),
    .advance (sweep_adv),
    .row     (row),
    .onehot  (row_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      k_q         <= '0;
      kk_q        <= '0;
      if_last_q   <= '0;
      pass_last_q <= '0;
      pass_cnt    <= '0;
      wt_cnt      <= '0;
      if_cnt      <= '0;
      row_beat    <= '0;
      mac_cnt     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        pass_cnt <= '0;
        wt_cnt   <= '0;
        if_cnt   <= '0;
        row_beat <= '0;
        mac_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_legal) begin
                k_q         <= cfg_filt_size;
                kk_q        <= 5'(cfg_filt_size * cfg_filt_size);
                if_last_q   <= IF_W'(Y_DIM * cfg_filt_size - 1);
                pass_last_q <= cfg_num_pass - 1'b1;
                state       <= S_LOAD_WT;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_LOAD_WT: begin
            if (feed_valid) begin
              if (wt_cnt == kk_q - 5'd1) begin
                wt_cnt <= '0;
                state  <= S_LOAD_IF;
              end else begin
                wt_cnt <= wt_cnt + 1'b1;
              end
            end
          end
          S_LOAD_IF: begin
            if (feed_valid) begin
              row_beat <= (row_beat == k_q - 4'd1) ? '0 : row_beat + 1'b1;
              if (if_cnt == if_last_q) begin
                if_cnt <= '0;
                state  <= S_MAC;
              end else begin
                if_cnt <= if_cnt + 1'b1;
              end
            end
          end
          S_MAC: begin
            if (mac_cnt == mac_last) begin
              mac_cnt <= '0;
              state   <= S_DRAIN;
            end else begin
              mac_cnt <= mac_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (drain_ready && (row == ROW_W'(Y_DIM - 1))) begin
              if (pass_cnt < pass_last_q) begin
                pass_cnt <= pass_cnt + 1'b1;
                state    <= S_LOAD_IF;
              end else begin
                pass_cnt <= '0;
                state    <= S_DONE;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    feed_ready      = 1'b0;
    pe_mux_ctrl     = '0;
    pe_compute_ctrl = '0;
    pe_wt_rf_wr_en  = 1'b0;
    pe_if_rf_wr_en  = '0;
    pe_of_rf_wr_en  = '0;
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    cfg_err         = cfg_err_q;
    case (state)
      S_LOAD_WT: begin
        feed_ready             = 1'b1;
        pe_mux_ctrl[MUX_WT_IN] = 1'b1;
        pe_wt_rf_wr_en         = feed_valid;
      end
      S_LOAD_IF: begin
        feed_ready               = 1'b1;
        pe_mux_ctrl[MUX_ACTN_IN] = 1'b1;
        pe_if_rf_wr_en           = row_onehot & {Y_DIM{feed_valid}};
      end
      S_MAC: begin
        if (mac_cnt == 6'd0) begin
          pe_compute_ctrl[CMP_ACC_CLR]   = 1'b1;
          pe_compute_ctrl[CMP_MULT_LOAD] = 1'b1;
        end
        if ((mac_cnt != 6'd0) && (mac_cnt <= {1'b0, kk_q})) begin
          pe_compute_ctrl[CMP_MULT_EN] = 1'b1;
        end
        if (mac_cnt >= 6'(MAC_PIPE_DEPTH)) begin
          pe_compute_ctrl[CMP_ADD_EN]    = 1'b1;
          pe_compute_ctrl[CMP_ACC_WR_EN] = 1'b1;
          pe_mux_ctrl[MUX_ADD_IN]        = 1'b1;
        end
      end
      S_DRAIN: begin
        pe_mux_ctrl[MUX_PE_OUT] = 1'b1;
        pe_of_rf_wr_en          = row_onehot & {Y_DIM{drain_ready}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl: phase/beat-count reference model
// compared every cycle, plus directed tiles with hand-computed timings.
module tb_pe_array_ctrl;

  localparam int Y  = 5;
  localparam int MK = 5;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, feed_valid, drain_ready;
  logic [3:0]    cfg_filt_size;
  logic [PW-1:0] cfg_num_pass;
  logic          feed_ready, pe_wt_rf_wr_en, busy, done, cfg_err;
  logic [3:0]    pe_mux_ctrl;
  logic [4:0]    pe_compute_ctrl;
  logic [Y-1:0]  pe_if_rf_wr_en, pe_of_rf_wr_en;

  pe_array_ctrl #(
    .Y_DIM  (Y),
    .MAX_K  (MK),
    .PASS_W (PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_filt_size   (cfg_filt_size),
    .cfg_num_pass    (cfg_num_pass),
    .feed_valid      (feed_valid),
    .feed_ready      (feed_ready),
    .drain_ready     (drain_ready),
    .pe_mux_ctrl     (pe_mux_ctrl),
    .pe_compute_ctrl (pe_compute_ctrl),
    .pe_wt_rf_wr_en  (pe_wt_rf_wr_en),
    .pe_if_rf_wr_en  (pe_if_rf_wr_en),
    .pe_of_rf_wr_en  (pe_of_rf_wr_en),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 weights, 2 activations, 3 MAC, 4 drain, 5 done;
  // m_n counts beats/cycles completed within the current phase.
  int m_ph = 0, m_n = 0, m_pass = 0, m_k = 1, m_np = 1;
  bit m_err = 0, m_valid = 0;

  int n_wt = 0, n_if = 0, n_of = 0, n_done = 0, n_err = 0;
  int n_clr = 0, n_mult = 0, n_add = 0;
  int last_done_cyc = -1;

  always @(negedge clk) begin
    int e_fr, e_wt, e_if, e_of, e_mux, e_cmp, kk;
    if (m_valid) begin
      e_fr = 0; e_wt = 0; e_if = 0; e_of = 0; e_mux = 0; e_cmp = 0;
      kk = m_k * m_k;
      case (m_ph)
        1: begin e_fr = 1; e_mux = 2; e_wt = int'(feed_valid); end
        2: begin
          e_fr = 1; e_mux = 1;
          e_if = feed_valid ? (1 << (m_n / m_k)) : 0;
        end
        3: begin
          if (m_n == 0) e_cmp = e_cmp | 4 | 8;
          if (m_n >= 1 && m_n <= kk) e_cmp = e_cmp | 1;
          if (m_n >= 2 && m_n <= kk + 1) begin e_cmp = e_cmp | 2 | 16; e_mux = 4; end
        end
        4: begin e_mux = 8; e_of = drain_ready ? (1 << m_n) : 0; end
        default: ;
      endcase
      chk("feed_ready", int'(feed_ready), e_fr);
      chk("wt_rf_wr_en", int'(pe_wt_rf_wr_en), e_wt);
      chk("if_rf_wr_en", int'(pe_if_rf_wr_en), e_if);
      chk("of_rf_wr_en", int'(pe_of_rf_wr_en), e_of);
      chk("mux_ctrl", int'(pe_mux_ctrl), e_mux);
      chk("compute_ctrl", int'(pe_compute_ctrl), e_cmp);
      chk("busy", int'(busy), int'(m_ph != 0));
      chk("done", int'(done), int'(m_ph == 5));
      chk("cfg_err", int'(cfg_err), int'(m_err));
    end

    n_wt   += int'(pe_wt_rf_wr_en);
    n_if   += $countones(pe_if_rf_wr_en);
    n_of   += $countones(pe_of_rf_wr_en);
    n_done += int'(done);
    n_err  += int'(cfg_err);
    n_clr  += int'(pe_compute_ctrl[2]);
    n_mult += int'(pe_compute_ctrl[0]);
    n_add  += int'(pe_compute_ctrl[1]);
    if (done) last_done_cyc = cyc;

    if (rst) begin
      m_valid = 1; m_ph = 0; m_n = 0; m_pass = 0; m_err = 0;
    end else if (m_valid) begin
      m_err = 0;
      if (abort) begin
        m_ph = 0; m_n = 0; m_pass = 0;
      end else begin
        case (m_ph)
          0: if (start) begin
            if (cfg_filt_size >= 1 && cfg_filt_size <= MK && cfg_num_pass != 0) begin
              m_ph = 1; m_n = 0; m_pass = 0;
              m_k = int'(cfg_filt_size); m_np = int'(cfg_num_pass);
            end else begin
              m_err = 1;
            end
          end
          1: if (feed_valid) begin
            m_n++;
            if (m_n == m_k * m_k) begin m_ph = 2; m_n = 0; end
          end
          2: if (feed_valid) begin
            m_n++;
            if (m_n == Y * m_k) begin m_ph = 3; m_n = 0; end
          end
          3: begin
            m_n++;
            if (m_n == m_k * m_k + 2) begin m_ph = 4; m_n = 0; end
          end
          4: if (drain_ready) begin
            m_n++;
            if (m_n == Y) begin
              m_n = 0;
              if (m_pass + 1 < m_np) begin m_pass++; m_ph = 2; end
              else m_ph = 5;
            end
          end
          default: m_ph = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s_wt, s_if, s_of, s_done, s_clr, s_mult, s_add;
  task automatic snap();
    s_wt = n_wt; s_if = n_if; s_of = n_of; s_done = n_done;
    s_clr = n_clr; s_mult = n_mult; s_add = n_add;
  endtask

  // mode 0: always valid/ready; 1: feed stall at r=4..6; 2: drain_ready = r[0]
  task automatic drive_mode(input int mode, input int r);
    feed_valid  = !(mode == 1 && r >= 4 && r <= 6);
    drain_ready = (mode == 2) ? r[0] : 1'b1;
  endtask

  task automatic tile(input int k, input int np, input int mode, input int abort_at,
                      input int rst_at, output int c0, output int r_end);
    int r;
    cfg_filt_size = 4'(k);
    cfg_num_pass  = PW'(np);
    start = 1'b1;
    c0 = cyc;
    drive_mode(mode, 0);
    r = 0;
    r_end = -1;
    while (r < 600) begin
      tick();
      r = cyc - c0;
      start = 1'b0;
      drive_mode(mode, r);
      abort = (r == abort_at);
      rst   = (r == rst_at);
      if (r >= 2 && !busy && !rst && !abort) begin
        r_end = r;
        break;
      end
    end
    chk("tile_terminates", int'(r_end >= 0), 1);
  endtask

  initial begin
    int c0, r_end;
    rst = 1'b1; start = 1'b0; abort = 1'b0; feed_valid = 1'b0; drain_ready = 1'b0;
    cfg_filt_size = '0; cfg_num_pass = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal tile
    snap();
    tile(3, 1, 0, -1, -1, c0, r_end);
    chk("nom_done_cycle", last_done_cyc - c0, 41);
    chk("nom_idle_cycle", r_end, 42);
    chk("nom_wt_writes", n_wt - s_wt, 9);
    chk("nom_if_writes", n_if - s_if, 15);
    chk("nom_of_writes", n_of - s_of, 5);
    chk("nom_done_count", n_done - s_done, 1);
    chk("nom_model_k", m_k, 3);
    tick();

    // Feed stall
    snap();
    tile(3, 1, 1, -1, -1, c0, r_end);
    chk("stall_done_cycle", last_done_cyc - c0, 44);
    chk("stall_wt_writes", n_wt - s_wt, 9);
    tick();

    // Multi-pass
    snap();
    tile(2, 3, 0, -1, -1, c0, r_end);
    chk("mp_wt_writes", n_wt - s_wt, 4);
    chk("mp_if_writes", n_if - s_if, 30);
    chk("mp_of_writes", n_of - s_of, 15);
    chk("mp_done_count", n_done - s_done, 1);
    chk("mp_mac_windows", n_clr - s_clr, 3);
    chk("mp_mult_cycles", n_mult - s_mult, 12);
    chk("mp_add_cycles", n_add - s_add, 12);
    chk("mp_model_np", m_np, 3);
    tick();

    // Config errors
    for (int i = 0; i < 3; i++) begin
      cfg_filt_size = (i == 0) ? 4'd0 : (i == 1) ? 4'd6 : 4'd3;
      cfg_num_pass  = (i == 2) ? PW'(0) : PW'(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      chk("cfg_err_busy", int'(busy), 0);
      tick();
      chk("cfg_err_single", int'(cfg_err), 0);
    end

    // Abort during MAC c=3
    snap();
    tile(3, 1, 0, 28, -1, c0, r_end);
    chk("abort_idle_cycle", r_end, 29);
    chk("abort_no_done", n_done - s_done, 0);
    tick();

    // Drain backpressure with K=1
    snap();
    tile(1, 1, 2, -1, -1, c0, r_end);
    chk("bp_done_cycle", last_done_cyc - c0, 20);
    chk("bp_of_writes", n_of - s_of, 5);
    tick();

    // Reset mid-LOAD_IF, then a fresh tile
    snap();
    tile(3, 1, 0, -1, 15, c0, r_end);
    chk("rst_idle_cycle", r_end, 16);
    chk("rst_no_done", n_done - s_done, 0);
    snap();
    tile(2, 1, 0, -1, -1, c0, r_end);
    chk("post_rst_done_cycle", last_done_cyc - c0, 26);
    chk("post_rst_wt_writes", n_wt - s_wt, 4);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst           = ($urandom % 1500) == 0;
      start         = ($urandom % 12) == 0;
      abort         = ($urandom % 250) == 0;
      cfg_filt_size = 4'($urandom % 8);
      cfg_num_pass  = PW'($urandom % 4);
      feed_valid    = ($urandom % 4) != 0;
      drain_ready   = ($urandom % 3) != 0;
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for the PE array. It generates the mux-select, compute-enable and register-file write-enable vectors that drive the array for one convolution tile. A tile is: load weights, then one or more passes of (load activations, MAC, drain outputs). It sits between the top-level layer controller (start/config/done) and the PE array; the buffer side supplies data under a valid/ready-style handshake.

Parameters:
Y_DIM, 5, number of PE rows; width of the per-row if/of write enables
MAX_K, 5, largest legal filter size; must be <= Y_DIM
PASS_W, 8, width of the pass count

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  tile start pulse; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE
cfg_filt_size  in  4  filter size K; legal range 1..MAX_K
cfg_num_pass  in  PASS_W  number of activation passes; legal range >= 1
feed_valid  in  1  buffer presents a weight/activation beat this cycle
feed_ready  out  1  controller consumes a beat this cycle
drain_ready  in  1  output buffer accepts one PE-row result this cycle
pe_mux_ctrl  out  4  [0] actn_in_sel, [1] wt_in_sel, [2] add_in_sel, [3] pe_out_sel
pe_compute_ctrl  out  5  [0] mult_en, [1] add_en, [2] acc_clr, [3] mult_load, [4] acc_wr_en
pe_wt_rf_wr_en  out  1  weight register-file write enable (broadcast)
pe_if_rf_wr_en  out  Y_DIM  per-row activation register-file write enable
pe_of_rf_wr_en  out  Y_DIM  per-row output register-file write enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on tile completion
cfg_err  out  1  one-cycle pulse when start carries an illegal config

Behaviour:
- All outputs are decoded from registered state and counters only; no input-to-output combinational path except feed_ready and the write enables qualified by feed_valid/drain_ready as stated below.
- Reset: state IDLE, all counters 0, every output 0.
- States: IDLE, LOAD_WT, LOAD_IF, MAC, DRAIN, DONE.
- IDLE:
  - start=1 with legal config latches K and the pass count, then goes to LOAD_WT next cycle.
  - Illegal config (K=0, K>MAX_K, or num_pass=0) pulses cfg_err the next cycle and stays in IDLE.
  - start is ignored while busy=1.
- LOAD_WT:
  - feed_ready=1, wt_in_sel=1, pe_wt_rf_wr_en=feed_valid.
  - wt_cnt advances on each accepted beat; after K*K beats the next state is LOAD_IF.
  - Stalls indefinitely while feed_valid=0.
- LOAD_IF:
  - feed_ready=1, actn_in_sel=1.
  - Rows r=0..Y_DIM-1 receive K beats each; pe_if_rf_wr_en = onehot(r) & {Y_DIM{feed_valid}}.
  - After Y_DIM*K beats the next state is MAC. Stalls on feed_valid=0.
- MAC: fixed K*K+2 cycles, counter c, feed_ready=0, never stalls.
  - c=0: acc_clr=1, mult_load=1.
  - c=1..K*K: mult_en=1.
  - c=2..K*K+1: add_en=1, acc_wr_en=1, add_in_sel=1.
  - The next state is DRAIN.
- DRAIN:
  - pe_out_sel=1; row pointer r sweeps 0..Y_DIM-1.
  - pe_of_rf_wr_en = onehot(r) & {Y_DIM{drain_ready}}; r advances only when drain_ready=1.
  - After row Y_DIM-1 is accepted: if pass_cnt < num_pass-1, increment pass_cnt and go to LOAD_IF (weights retained). Otherwise go to DONE.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in the DONE cycle is ignored.
- abort=1 in any state: next cycle is IDLE with all counters cleared; the abort cycle's outputs still follow the current state. abort outranks a completing transition.
- Widths:
  - K*K is at most 25, so wt_cnt and MAC c are 5 bits and 6 bits.
  - LOAD_IF beat count is at most Y_DIM*MAX_K, sized by $clog2.
  - pass_cnt is PASS_W bits; no wrap is possible because the compare is against the latched num_pass-1.
- A mid-operation reset behaves exactly like the reset state above.

Decomposition:
- Shared package pe_ctrl_pkg:
  - state enum typedef.
  - Bit-index localparams for pe_mux_ctrl and pe_compute_ctrl fields, also used by pe_array.
  - A MAC pipeline-depth constant (2).
- One natural sub-module, pe_row_sweep: a row pointer plus one-hot decoder with advance/clear, reused by LOAD_IF and DRAIN.

Test Plan:
- Nominal tile:
  - Stimulus: K=3, num_pass=1, feed_valid=1 and drain_ready=1 throughout; start at cycle 0.
  - Response: LOAD_WT cycles 1-9 (9 pe_wt_rf_wr_en); LOAD_IF cycles 10-24 (15 beats, each row one-hot for 3 cycles); MAC cycles 25-35; DRAIN cycles 36-40 (rows 0..4); done=1 at cycle 41; busy low at 42.
- Feed stall:
  - Stimulus: same as nominal, with feed_valid=0 for cycles 4-6.
  - Response: wt_rf writes pause; still exactly 9 wt writes; done shifts to cycle 44.
- Multi-pass:
  - Stimulus: K=2, num_pass=3.
  - Response: exactly 4 wt writes total; 3×10 if writes; 3 MAC windows of 6 cycles; 15 of writes; a single done pulse.
- Config errors:
  - Stimulus: start with K=0, then K=6, then num_pass=0.
  - Response: cfg_err pulses one cycle later each time; busy stays 0; no enables asserted.
- Abort and drain backpressure:
  - Stimulus: abort during MAC c=3.
  - Response: IDLE next cycle, all outputs 0, no done.
  - Stimulus: drain_ready toggling 1/0 during DRAIN.
  - Response: of writes only on drain_ready=1 cycles, rows in order 0..4.
- Reset mid-LOAD_IF:
  - Stimulus: rst asserted during LOAD_IF.
  - Response: all outputs 0 the following cycle; a new start after reset begins at LOAD_WT with wt_cnt=0.
